apb_burst_master: RTL and testbench

Parametrised APB master engine for the AXI2APB bridge. It executes one multi-beat read or write command from the bridge engine as a sequence of APB transfers across NUM_SLAVES decoded slaves. Write data is pulled from the write FIFO and read data is pushed into the read FIFO. It reports a single burst response that aggregates slave errors, decode errors and per-beat timeouts.

---
 rtl/apb_burst_master_pkg.sv | 28 ++
 rtl/apb_slave_decoder.sv | 22 ++
 rtl/apb_burst_master.sv | 202 ++++++++++++++++++++
 tb/tb_apb_burst_master.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_burst_master_pkg.sv
// Shared types for the APB burst master: engine states, APB responses and burst kinds.
// Response encodings rise with severity, so the sticky merge is a simple maximum.
package apb_burst_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_DATA,
      ST_SETUP,
      ST_ACCESS,
      ST_DONE
   } apb_state_t;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } apb_resp_t;

   typedef enum logic {
      BURST_INCR  = 1'b0,
      BURST_FIXED = 1'b1
   } burst_t;

   function automatic apb_resp_t resp_merge(input apb_resp_t a, input apb_resp_t b);
      return (b > a) ? b : a;
   endfunction

endpackage

// File: rtl/apb_slave_decoder.sv
// Combinational slave decode: upper address field to one-hot select, index and decode error.
module apb_slave_decoder #(
   parameter int unsigned IDX_W      = 20,
   parameter int unsigned NUM_SLAVES = 4,
   parameter int unsigned SEL_W      = 2
) (
   input  logic [IDX_W-1:0]      slot,
   output logic [NUM_SLAVES-1:0] sel,
   output logic [SEL_W-1:0]      idx,
   output logic                  dec_err
);

   always_comb begin
      dec_err = (slot >= IDX_W'(NUM_SLAVES));
      idx     = SEL_W'(slot);
      sel     = '0;
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
         sel[i] = !dec_err && (slot == IDX_W'(i));
      end
   end

endmodule

// File: rtl/apb_burst_master.sv
// APB master engine: runs one multi-beat read or write command as a chain of APB transfers,
// moving data between the bridge FIFOs and the decoded slaves and reporting one burst response.
module apb_burst_master
   import apb_burst_master_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned NUM_SLAVES     = 4,
   parameter int unsigned SLV_ADDR_BITS  = 12,
   parameter int unsigned LEN_WIDTH      = 8,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cmd_valid,
   output logic                             cmd_ready,
   input  logic                             cmd_write,
   input  logic [ADDR_WIDTH-1:0]            cmd_addr,
   input  logic [LEN_WIDTH-1:0]             cmd_len,
   input  logic                             cmd_fixed,
   output logic                             done_valid,
   output logic [1:0]                       done_resp,
   input  logic                             wfifo_empty,
   output logic                             wfifo_rd,
   input  logic [DATA_WIDTH-1:0]            wfifo_data,
   input  logic                             rfifo_full,
   output logic                             rfifo_wr,
   output logic [DATA_WIDTH-1:0]            rfifo_data,
   output logic [NUM_SLAVES-1:0]            psel,
   output logic                             penable,
   output logic                             pwrite,
   output logic [ADDR_WIDTH-1:0]            paddr,
   output logic [DATA_WIDTH-1:0]            pwdata,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
   input  logic [NUM_SLAVES-1:0]            pready,
   input  logic [NUM_SLAVES-1:0]            pslverr
);

   localparam int unsigned IDX_W  = ADDR_WIDTH - SLV_ADDR_BITS;
   localparam int unsigned SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
   localparam int unsigned TC_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned STRIDE = DATA_WIDTH / 8;

   apb_state_t             state, state_nxt;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_nxt;
   logic                   write_q, write_nxt;
   burst_t                 burst_q, burst_nxt;
   logic [LEN_WIDTH-1:0]   beats_q, beats_nxt;
   apb_resp_t              resp_q, resp_nxt;
   logic [TC_W-1:0]        tcnt_q, tcnt_nxt;
   apb_resp_t              done_resp_q, done_resp_nxt;
   logic                   done_valid_nxt;
   logic [NUM_SLAVES-1:0]  psel_nxt;
   logic                   penable_nxt, pwrite_nxt;
   logic [ADDR_WIDTH-1:0]  paddr_nxt;
   logic [DATA_WIDTH-1:0]  pwdata_nxt;

   logic [NUM_SLAVES-1:0]  sel;
   logic [SEL_W-1:0]       idx;
   logic                   dec_err;
   logic [DATA_WIDTH-1:0]  rd_slice;
   logic                   rdy, slv_err, timeout_hit, beat_done, fifo_ok;
   apb_resp_t              beat_resp, merged_resp;

   // The current beat address is re-decoded every beat so INCR bursts may cross slave windows.
   apb_slave_decoder #(
      .IDX_W      (IDX_W),
      .NUM_SLAVES (NUM_SLAVES),
      .SEL_W      (SEL_W)
   ) u_dec (
      .slot    (addr_q[ADDR_WIDTH-1:SLV_ADDR_BITS]),
      .sel     (sel),
      .idx     (idx),
      .dec_err (dec_err)
   );

   always_comb begin
      rd_slice = '0;
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
         if (idx == SEL_W'(i)) rd_slice = prdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Beat completion, response classification and the combinational FIFO handshakes.
   always_comb begin
      rdy         = |(pready & sel);
      slv_err     = |(pslverr & sel);
      timeout_hit = (tcnt_q == TC_W'(TIMEOUT_CYCLES - 1));
      fifo_ok     = write_q ? !wfifo_empty : !rfifo_full;
      beat_done   = (state == ST_ACCESS) && (dec_err || rdy || timeout_hit);
      if (dec_err || !rdy)  beat_resp = RESP_DECERR;
      else if (slv_err)     beat_resp = RESP_SLVERR;
      else                  beat_resp = RESP_OKAY;
      merged_resp = resp_merge(resp_q, beat_resp);
      cmd_ready   = (state == ST_IDLE) && !rst;
      wfifo_rd    = (state == ST_WAIT_DATA) && write_q && !wfifo_empty;
      rfifo_wr    = beat_done && !write_q;
      rfifo_data  = (rfifo_wr && rdy) ? rd_slice : '0;
   end

   always_comb begin
      state_nxt      = state;
      addr_nxt       = addr_q;
      write_nxt      = write_q;
      burst_nxt      = burst_q;
      beats_nxt      = beats_q;
      resp_nxt       = resp_q;
      tcnt_nxt       = tcnt_q;
      psel_nxt       = psel;
      penable_nxt    = penable;
      pwrite_nxt     = pwrite;
      paddr_nxt      = paddr;
      pwdata_nxt     = pwdata;
      done_valid_nxt = 1'b0;
      done_resp_nxt  = done_resp_q;
      case (state)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               addr_nxt  = cmd_addr;
               write_nxt = cmd_write;
               burst_nxt = cmd_fixed ? BURST_FIXED : BURST_INCR;
               beats_nxt = cmd_len;
               resp_nxt  = RESP_OKAY;
               state_nxt = ST_WAIT_DATA;
            end
         end
         ST_WAIT_DATA: begin
            // A stalled FIFO holds the burst here indefinitely; the timeout only covers ACCESS.
            if (fifo_ok) begin
               state_nxt   = ST_SETUP;
               psel_nxt    = sel;
               penable_nxt = 1'b0;
               paddr_nxt   = addr_q;
               pwrite_nxt  = write_q;
               if (write_q) pwdata_nxt = wfifo_data;
            end
         end
         ST_SETUP: begin
            state_nxt   = ST_ACCESS;
            penable_nxt = !dec_err;
            tcnt_nxt    = '0;
         end
         ST_ACCESS: begin
            tcnt_nxt = tcnt_q + TC_W'(1);
            if (beat_done) begin
               resp_nxt    = merged_resp;
               psel_nxt    = '0;
               penable_nxt = 1'b0;
               tcnt_nxt    = '0;
               if (burst_q == BURST_INCR) addr_nxt = addr_q + ADDR_WIDTH'(STRIDE);
               if (beats_q == '0) begin
                  state_nxt      = ST_DONE;
                  done_valid_nxt = 1'b1;
                  done_resp_nxt  = merged_resp;
               end else begin
                  beats_nxt = beats_q - LEN_WIDTH'(1);
                  state_nxt = ST_WAIT_DATA;
               end
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         addr_q      <= '0;
         write_q     <= 1'b0;
         burst_q     <= BURST_INCR;
         beats_q     <= '0;
         resp_q      <= RESP_OKAY;
         tcnt_q      <= '0;
         psel        <= '0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         done_valid  <= 1'b0;
         done_resp_q <= RESP_OKAY;
      end else begin
         state       <= state_nxt;
         addr_q      <= addr_nxt;
         write_q     <= write_nxt;
         burst_q     <= burst_nxt;
         beats_q     <= beats_nxt;
         resp_q      <= resp_nxt;
         tcnt_q      <= tcnt_nxt;
         psel        <= psel_nxt;
         penable     <= penable_nxt;
         pwrite      <= pwrite_nxt;
         paddr       <= paddr_nxt;
         pwdata      <= pwdata_nxt;
         done_valid  <= done_valid_nxt;
         done_resp_q <= done_resp_nxt;
      end
   end

   assign done_resp = done_resp_q;

endmodule

// File: tb/tb_apb_burst_master.sv
// Self-checking bench for apb_burst_master: a table of bursts with hand-computed results
// against a simple slave/FIFO model, plus reset-state and reset-mid-burst sequences.
module tb_apb_burst_master;

   localparam logic [31:0] RD_BASE = 32'hA5A5_0000;
   localparam logic [31:0] WR_BASE = 32'h1111_0000;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_write, cmd_fixed;
   logic [31:0]   cmd_addr;
   logic [7:0]    cmd_len;
   logic          done_valid;
   logic [1:0]    done_resp;
   logic          wfifo_empty, wfifo_rd, rfifo_full, rfifo_wr;
   logic [31:0]   wfifo_data, rfifo_data, paddr, pwdata;
   logic [3:0]    psel, pready, pslverr;
   logic          penable, pwrite;
   logic [127:0]  prdata;

   apb_burst_master dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_fixed(cmd_fixed),
      .done_valid(done_valid), .done_resp(done_resp),
      .wfifo_empty(wfifo_empty), .wfifo_rd(wfifo_rd), .wfifo_data(wfifo_data),
      .rfifo_full(rfifo_full), .rfifo_wr(rfifo_wr), .rfifo_data(rfifo_data),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          write;
      logic [31:0] addr;
      int          len;
      bit          fixed;
      int          wait_c;
      bit          stuck;
      int          err_beat;
      int          stall;
      logic [1:0]  resp;
      int          beats;
      int          setups;
      logic [3:0]  psel_or;
      logic [31:0] first_pa;
      logic [31:0] last_pa;
      logic [31:0] d0;
      logic [31:0] d1;
      int          pen;
      int          lat;
   } vec_t;

   vec_t tbl [7];

   int checks = 0;
   int errors = 0;

   // Slave model knobs and state
   int  wait_cyc = 0;
   bit  stuck = 0;
   int  err_beat = -1;
   int  acc_cnt = 0;
   int  beat_no = 0;
   int  wpop = 0;
   bit  clr_req = 0;

   // Monitor state
   int          cyc = 0, acc_cyc = 0, done_lat = 0, done_cnt = 0;
   int          pops = 0, pushes = 0, setups = 0, pen_cycles = 0, setup_full = 0;
   logic [1:0]  done_resp_s;
   logic [3:0]  psel_or;
   logic [31:0] paddr_log  [16];
   logic [31:0] pwdata_log [16];
   logic        pwrite_log [16];
   logic [31:0] rdata_log  [16];

   assign wfifo_data = WR_BASE + 32'(wpop);

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         pready[i]  = psel[i] && penable && !stuck && (acc_cnt == wait_cyc);
         pslverr[i] = pready[i] && (beat_no == err_beat);
         prdata[i*32 +: 32] = psel[i] ? (RD_BASE + 32'(beat_no) + 32'd1) : (32'hDEAD_0000 | 32'(i));
      end
   end

   always @(posedge clk) begin
      if (wfifo_rd) wpop <= wpop + 1;
      if (|psel && penable && !(|pready)) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
      if (clr_req) beat_no <= 0;
      else if (|(psel & pready) && penable) beat_no <= beat_no + 1;
   end

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (clr_req) begin
         pops = 0; pushes = 0; setups = 0; pen_cycles = 0; setup_full = 0;
         done_cnt = 0; psel_or = 4'b0; done_resp_s = 2'b01;
      end else begin
         if (cmd_valid && cmd_ready) acc_cyc = cyc;
         if (wfifo_rd) pops = pops + 1;
         if (rfifo_wr) begin
            if (pushes < 16) rdata_log[pushes] = rfifo_data;
            pushes = pushes + 1;
         end
         if (|psel && !penable) begin
            if (setups < 16) begin
               paddr_log[setups]  = paddr;
               pwdata_log[setups] = pwdata;
               pwrite_log[setups] = pwrite;
            end
            setups  = setups + 1;
            psel_or = psel_or | psel;
            if (rfifo_full) setup_full = setup_full + 1;
         end
         if (penable) pen_cycles = pen_cycles + 1;
         if (done_valid) begin
            if (done_cnt == 0) begin
               done_lat    = cyc - acc_cyc;
               done_resp_s = done_resp;
            end
            done_cnt = done_cnt + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      @(posedge clk); #1;
      clr_req = 1'b1;
      @(posedge clk); #1;
      clr_req = 1'b0;
   endtask

   task automatic issue(input vec_t v);
      int b;
      b = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b1;
      cmd_write = v.write;
      cmd_addr  = v.addr;
      cmd_len   = 8'(v.len);
      cmd_fixed = v.fixed;
      @(negedge clk);
      while (!cmd_ready && b < 50) begin
         @(negedge clk);
         b++;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_addr  = 32'hFFFF_0000;
   endtask

   task automatic run_burst(input vec_t v, input string tag);
      int wbase;
      int budget;
      wait_cyc = v.wait_c;
      stuck    = v.stuck;
      err_beat = v.err_beat;
      clear_mon();
      wbase = wpop;
      if (v.stall > 0) begin
         if (v.write) wfifo_empty = 1'b1;
         else rfifo_full = 1'b1;
      end
      issue(v);
      if (v.stall > 0) begin
         repeat (v.stall) @(posedge clk);
         #1;
         wfifo_empty = 1'b0;
         rfifo_full  = 1'b0;
      end
      budget = 0;
      while (done_cnt == 0 && budget < 400) begin
         @(negedge clk);
         budget++;
      end
      repeat (3) @(negedge clk);
      chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
      chk({tag, "_resp"}, 64'(done_resp_s), 64'(v.resp));
      chk({tag, "_pops"}, 64'(pops), v.write ? 64'(v.beats) : 64'd0);
      chk({tag, "_pushes"}, 64'(pushes), v.write ? 64'd0 : 64'(v.beats));
      chk({tag, "_setups"}, 64'(setups), 64'(v.setups));
      chk({tag, "_psel"}, 64'(psel_or), 64'(v.psel_or));
      chk({tag, "_pen_cycles"}, 64'(pen_cycles), 64'(v.pen));
      if (v.lat >= 0) chk({tag, "_latency"}, 64'(done_lat), 64'(v.lat));
      if (v.setups > 0 && setups > 0) begin
         chk({tag, "_paddr_first"}, 64'(paddr_log[0]), 64'(v.first_pa));
         chk({tag, "_paddr_last"}, 64'(paddr_log[(setups > 16 ? 16 : setups) - 1]), 64'(v.last_pa));
         chk({tag, "_pwrite"}, 64'(pwrite_log[0]), 64'(v.write));
      end
      if (v.write) begin
         for (int k = 0; k < setups && k < 16; k++)
            chk({tag, "_pwdata"}, 64'(pwdata_log[k]), 64'(WR_BASE + 32'(wbase) + 32'(k)));
      end else begin
         chk({tag, "_setup_while_full"}, 64'(setup_full), 64'd0);
         if (pushes > 0) chk({tag, "_rdata0"}, 64'(rdata_log[0]), 64'(v.d0));
         if (v.beats > 1 && pushes > 1) chk({tag, "_rdata1"}, 64'(rdata_log[1]), 64'(v.d1));
      end
   endtask

   task automatic check_outputs_reset(input string tag);
      chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd0);
      chk({tag, "_done_valid"}, 64'(done_valid), 64'd0);
      chk({tag, "_done_resp"}, 64'(done_resp), 64'd0);
      chk({tag, "_psel"}, 64'(psel), 64'd0);
      chk({tag, "_penable"}, 64'(penable), 64'd0);
      chk({tag, "_pwrite"}, 64'(pwrite), 64'd0);
      chk({tag, "_paddr"}, 64'(paddr), 64'd0);
      chk({tag, "_pwdata"}, 64'(pwdata), 64'd0);
      chk({tag, "_wfifo_rd"}, 64'(wfifo_rd), 64'd0);
      chk({tag, "_rfifo_wr"}, 64'(rfifo_wr), 64'd0);
      chk({tag, "_rfifo_data"}, 64'(rfifo_data), 64'd0);
   endtask

   initial begin
      vec_t rv;
      int   b;
      //          wr addr           len fx wt st eb  stl  resp   bt su psel     first_pa       last_pa        d0             d1             pen lat
      tbl[0] = '{1, 32'h0000_1000, 3, 0, 0, 0, -1, 0,  2'b00, 4, 4, 4'b0010, 32'h0000_1000, 32'h0000_100C, 32'h0,         32'h0,         4,  13};
      tbl[1] = '{0, 32'h0000_2000, 1, 1, 2, 0, -1, 0,  2'b00, 2, 2, 4'b0100, 32'h0000_2000, 32'h0000_2000, 32'hA5A5_0001, 32'hA5A5_0002, 6,  11};
      tbl[2] = '{0, 32'h0000_0040, 0, 0, 0, 1, -1, 0,  2'b11, 1, 1, 4'b0001, 32'h0000_0040, 32'h0000_0040, 32'h0,         32'h0,         16, 19};
      tbl[3] = '{1, 32'h0000_5000, 0, 0, 0, 0, -1, 0,  2'b11, 1, 0, 4'b0000, 32'h0,         32'h0,         32'h0,         32'h0,         0,  4};
      tbl[4] = '{0, 32'h0000_3000, 3, 0, 0, 0, 1,  10, 2'b10, 4, 4, 4'b1000, 32'h0000_3000, 32'h0000_300C, 32'hA5A5_0001, 32'hA5A5_0002, 4,  -1};
      tbl[5] = '{1, 32'h0000_1FF8, 2, 0, 0, 0, -1, 5,  2'b00, 3, 3, 4'b0110, 32'h0000_1FF8, 32'h0000_2000, 32'h0,         32'h0,         3,  -1};
      tbl[6] = '{0, 32'hFFFF_FFFC, 1, 0, 0, 0, -1, 0,  2'b11, 2, 1, 4'b0001, 32'h0000_0000, 32'h0000_0000, 32'h0,         32'hA5A5_0001, 1,  7};

      rst = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_len = 8'h0; cmd_fixed = 1'b0;
      wfifo_empty = 1'b0; rfifo_full = 1'b0;
      #3;
      check_outputs_reset("por");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("por_cmd_ready_after_release", 64'(cmd_ready), 64'd1);

      for (int i = 0; i < 7; i++) run_burst(tbl[i], $sformatf("vec%0d", i));

      // Reset asserted in the middle of beat 2 of an 8-beat write.
      rv = tbl[0];
      rv.len = 7;
      wait_cyc = 0; stuck = 0; err_beat = -1;
      clear_mon();
      issue(rv);
      b = 0;
      while (setups < 2 && b < 100) begin
         @(negedge clk);
         b++;
      end
      chk("midrst_reached_beat2", 64'(setups), 64'd2);
      chk("midrst_psel_before", 64'(psel), 64'h2);
      #2 rst = 1'b1;
      #1;
      check_outputs_reset("midrst");
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_cmd_ready_after", 64'(cmd_ready), 64'd1);
      repeat (20) @(negedge clk);
      chk("midrst_no_done", 64'(done_cnt), 64'd0);
      chk("midrst_no_more_beats", 64'(setups), 64'd2);
      run_burst(tbl[0], "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
